pwm_multi: RTL and testbench



---
 rtl/pwm_multi_if.sv | 19 +
 rtl/pwm_multi.sv | 147 ++++++++++++++
 tb/tb_pwm_multi.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// Host action bus shared with the pio block: command in, read data out.
interface pwm_multi_if #(
    parameter int IW = 2
);
    logic [3:0]    action;
    logic [IW-1:0] index;
    logic [31:0]   din;
    logic [31:0]   dout;

    modport master (
        output action, index, din,
        input  dout
    );

    modport slave (
        input  action, index, din,
        output dout
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: per-channel 16.8 divider, double-buffered period/duty,
// edge- or centre-aligned counting with optional output inversion.
module pwm_multi #(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int IW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    pwm_multi_if.slave    bus,
    output logic [CH-1:0] pwm_out,
    output logic [CH-1:0] wrap
);
    typedef enum logic [3:0] {
        A_NONE   = 4'd0,
        A_PERIOD = 4'd1,
        A_DUTY   = 4'd2,
        A_DIV    = 4'd3,
        A_CTRL   = 4'd4,
        A_ENABLE = 4'd5,
        A_READ   = 4'd6
    } act_e;

    logic [IW-1:0] idx;
    logic [W-1:0]  ctr_all [CH];
    logic          unused_din;

    assign idx        = bus.index;
    assign unused_din = ^bus.din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dout <= '0;
        end else if (bus.action == A_READ && int'(idx) < CH) begin
            bus.dout <= 32'(ctr_all[idx]);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic          sel, en, en_n, dir, dir_n, wrp, carry;
        logic          po, po_n, wr;
        logic [W-1:0]  ctr, ctr_n, pa, pa_n, da, da_n, pp, dp;
        logic [15:0]   dcnt, dcnt_n, int_eff;
        logic [7:0]    acc, acc_n, acc_sum, frac_eff;
        logic [23:0]   div;
        logic [1:0]    ctrl;

        assign sel        = (idx == IW'(c));
        assign ctr_all[c] = ctr;
        assign pwm_out[c] = po;
        assign wrap[c]    = wr;

        always_comb begin
            int_eff  = (div[23:8] == 16'd0) ? 16'd1 : div[23:8];
            frac_eff = (div[23:8] == 16'd0) ? 8'd0 : div[7:0];
            {carry, acc_sum} = {1'b0, acc} + {1'b0, frac_eff};
            en_n   = en;
            ctr_n  = ctr;
            dir_n  = dir;
            dcnt_n = dcnt;
            acc_n  = acc;
            pa_n   = pa;
            da_n   = da;
            wrp    = 1'b0;
            if (bus.action == A_ENABLE) en_n = bus.din[c];
            if (!en) begin
                pa_n = pp;
                da_n = dp;
                if (en_n) begin
                    ctr_n  = '0;
                    dir_n  = 1'b0;
                    dcnt_n = '0;
                    acc_n  = '0;
                end
            end else if (en_n) begin
                if (dcnt != 16'd0) begin
                    dcnt_n = dcnt - 16'd1;
                end else begin
                    dcnt_n = int_eff - 16'd1 + {15'd0, carry};
                    acc_n  = acc_sum;
                    if (!ctrl[0]) begin
                        dir_n = 1'b0;
                        if (ctr >= pa) begin
                            ctr_n = '0;
                            wrp   = 1'b1;
                        end else begin
                            ctr_n = ctr + W'(1);
                        end
                    end else if (!dir) begin
                        if (ctr >= pa) begin
                            dir_n = 1'b1;
                            ctr_n = (pa == '0) ? '0 : ctr - W'(1);
                        end else begin
                            ctr_n = ctr + W'(1);
                        end
                    end else begin
                        if (ctr == '0) begin
                            dir_n = 1'b0;
                            ctr_n = (pa == '0) ? '0 : W'(1);
                            wrp   = 1'b1;
                        end else begin
                            ctr_n = ctr - W'(1);
                        end
                    end
                end
            end
            // Reload takes the pending value as it stood before this edge
            if (wrp) begin
                pa_n = pp;
                da_n = dp;
            end
            po_n = en_n ? ((ctr_n < da_n) ^ ctrl[1]) : ctrl[1];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                en   <= 1'b0;
                dir  <= 1'b0;
                ctr  <= '0;
                dcnt <= '0;
                acc  <= '0;
                pa   <= '0;
                da   <= '0;
                pp   <= '0;
                dp   <= '0;
                div  <= 24'h000100;
                ctrl <= '0;
                po   <= 1'b0;
                wr   <= 1'b0;
            end else begin
                en   <= en_n;
                dir  <= dir_n;
                ctr  <= ctr_n;
                dcnt <= dcnt_n;
                acc  <= acc_n;
                pa   <= pa_n;
                da   <= da_n;
                po   <= po_n;
                wr   <= wrp;
                if (sel && bus.action == A_PERIOD) pp <= bus.din[W-1:0];
                if (sel && bus.action == A_DUTY)   dp <= bus.din[W-1:0];
                if (sel && bus.action == A_DIV)    div <= bus.din[23:0];
                if (sel && bus.action == A_CTRL)   ctrl <= bus.din[2:1];
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: vector table plus multi-cycle sequences.
module tb_pwm_multi;
    logic       clk;
    logic       reset;
    logic [3:0] pwm_out;
    logic [3:0] wrap;
    int         checks;
    int         failures;

    pwm_multi_if #(.IW(2)) bus ();

    pwm_multi #(.CH(4), .W(16), .IW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pwm_out (pwm_out),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  act;
        logic [1:0]  idx;
        logic [31:0] din;
        logic [3:0]  pwm;
        logic [3:0]  wr;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[35];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] a, input logic [1:0] i,
                       input logic [31:0] d);
        bus.action = a;
        bus.index  = i;
        bus.din    = d;
        @(negedge clk);
    endtask

    initial begin
        int w1, w2, hi, du;
        logic [7:0] fpat;
        logic [3:0] e;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.action = '0;
        bus.index  = '0;
        bus.din    = '0;

        tbl[0] = '{act: 4'd1, idx: 2'd0, din: 32'd9, pwm: 4'd0, wr: 4'd0, dout: 32'd0};
        tbl[1] = '{act: 4'd2, idx: 2'd0, din: 32'd3, pwm: 4'd0, wr: 4'd0, dout: 32'd0};
        tbl[2] = '{act: 4'd5, idx: 2'd0, din: 32'd1, pwm: 4'd1, wr: 4'd0, dout: 32'd0};
        for (int k = 1; k <= 32; k++) begin
            du = (k < 10) ? 3 : ((k < 30) ? 7 : 2);
            tbl[2+k].act  = 4'd0;
            tbl[2+k].idx  = 2'd0;
            tbl[2+k].din  = 32'd0;
            if (k == 5)  begin tbl[2+k].act = 4'd2; tbl[2+k].din = 32'd7; end
            if (k == 20) begin tbl[2+k].act = 4'd2; tbl[2+k].din = 32'd2; end
            if (k == 13) tbl[2+k].act = 4'd6;
            tbl[2+k].pwm  = {3'b000, ((k % 10) < du)};
            tbl[2+k].wr   = {3'b000, ((k % 10) == 0)};
            tbl[2+k].dout = (k >= 13) ? 32'd2 : 32'd0;
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);

        for (int r = 0; r < 35; r++) begin
            cyc(tbl[r].act, tbl[r].idx, tbl[r].din);
            chk($sformatf("tbl%0d_pwm", r), 32'(pwm_out), 32'(tbl[r].pwm));
            chk($sformatf("tbl%0d_wrap", r), 32'(wrap), 32'(tbl[r].wr));
            chk($sformatf("tbl%0d_dout", r), bus.dout, tbl[r].dout);
        end

        cyc(4'd1, 2'd1, 32'd4);
        cyc(4'd2, 2'd1, 32'd2);
        cyc(4'd3, 2'd1, 32'h200);
        cyc(4'd4, 2'd1, 32'd2);
        cyc(4'd5, 2'd0, 32'd2);
        chk("ctr_en_pwm", 32'(pwm_out), 32'h2);
        w1 = -1;
        w2 = -1;
        hi = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            if (wrap[1]) begin
                if (w1 < 0) w1 = k;
                else if (w2 < 0) w2 = k;
            end
            if (w1 >= 0 && w2 < 0 && pwm_out[1]) hi++;
        end
        chk("ctr_first_wrap", 32'(w1), 32'd17);
        chk("ctr_wrap_spacing", 32'(w2 - w1), 32'd16);
        chk("ctr_high_clks", 32'(hi), 32'd6);

        cyc(4'd3, 2'd2, 32'h180);
        cyc(4'd1, 2'd2, 32'd0);
        cyc(4'd2, 2'd2, 32'd1);
        cyc(4'd4, 2'd2, 32'd0);
        cyc(4'd5, 2'd0, 32'd4);
        chk("frac_en_pwm", 32'(pwm_out), 32'h4);
        fpat = 8'b1101_1011;
        for (int k = 1; k <= 8; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            chk($sformatf("frac%0d_wrap", k), 32'(wrap[2]), 32'(fpat[k-1]));
            chk($sformatf("frac%0d_pwm", k), 32'(pwm_out[2]), 32'd1);
        end

        cyc(4'd5, 2'd0, 32'd0);
        chk("all_off_pwm", 32'(pwm_out), 32'd0);
        for (int c = 0; c < 4; c++) begin
            cyc(4'd1, 2'(c), 32'd9);
            cyc(4'd2, 2'(c), 32'(c + 1));
            cyc(4'd3, 2'(c), 32'h100);
            cyc(4'd4, 2'(c), 32'd0);
        end
        cyc(4'd5, 2'd0, 32'hF);
        chk("multi_start_pwm", 32'(pwm_out), 32'hF);
        for (int k = 1; k <= 11; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            for (int c = 0; c < 4; c++) e[c] = ((k % 10) < c + 1);
            chk($sformatf("multi%0d_pwm", k), 32'(pwm_out), 32'(e));
            chk($sformatf("multi%0d_wrap", k), 32'(wrap),
                (k == 10) ? 32'hF : 32'h0);
        end
        cyc(4'd5, 2'd0, 32'd0);
        chk("multi_stop_pwm", 32'(pwm_out), 32'd0);
        chk("multi_stop_wrap", 32'(wrap), 32'd0);
        cyc(4'd6, 2'd3, 32'd0);
        chk("frozen_ctr3", bus.dout, 32'd1);
        cyc(4'd6, 2'd0, 32'd0);
        chk("frozen_ctr0", bus.dout, 32'd1);
        cyc(4'd4, 2'd3, 32'd4);
        chk("inv_write_pwm", 32'(pwm_out), 32'd0);
        cyc(4'd0, 2'd0, 32'd0);
        chk("inv_idle_pwm", 32'(pwm_out), 32'h8);

        cyc(4'd3, 2'd3, 32'h300);
        cyc(4'd2, 2'd3, 32'd0);
        cyc(4'd5, 2'd0, 32'd8);
        chk("inv_run_pwm", 32'(pwm_out), 32'h8);
        for (int k = 1; k <= 4; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            chk($sformatf("inv_run%0d_pwm", k), 32'(pwm_out), 32'h8);
        end
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        chk("async_rst_dout", bus.dout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(4'd6, 2'd3, 32'd0);
        chk("post_rst_ctr3", bus.dout, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            chk($sformatf("post_rst%0d_pwm", k), 32'(pwm_out), 32'd0);
        end
        cyc(4'd1, 2'd3, 32'd3);
        cyc(4'd2, 2'd3, 32'd1);
        cyc(4'd5, 2'd0, 32'd8);
        chk("div1_start_pwm", 32'(pwm_out), 32'h8);
        for (int k = 1; k <= 8; k++) begin
            cyc(4'd0, 2'd0, 32'd0);
            chk($sformatf("div1_%0d_pwm", k), 32'(pwm_out),
                ((k % 4) == 0) ? 32'h8 : 32'h0);
            chk($sformatf("div1_%0d_wrap", k), 32'(wrap),
                ((k % 4) == 0) ? 32'h8 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
